patch_scan_ctrl: RTL

Sequencer for the 3x3 patch latch and its nine image memory read ports in the conv layer. It generates all nine pixel addresses and the `load` / `load_full_patch` strobes needed to slide a 3x3 window over the whole image, column by column and top to bottom within each column. It presents each latched patch to the downstream MAC stage with a valid/ready handshake and signals completion of the full scan.

---
 rtl/patch_scan_ctrl_if.sv | 47 ++++
 rtl/patch_scan_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/patch_scan_ctrl_if.sv
// Bundle of the scan sequencer's control, address and patch handshake signals.
// patch_valid/patch_ready: a patch transfers on a rising edge where both are 1;
// once raised, patch_valid stays high with stable latch contents and coordinates
// until that transfer happens.
interface patch_scan_ctrl_if #(
   parameter int ADDR_W = 10
) ();

   logic              start;
   logic              patch_ready;
   logic [ADDR_W-1:0] pixel_addr0;
   logic [ADDR_W-1:0] pixel_addr1;
   logic [ADDR_W-1:0] pixel_addr2;
   logic [ADDR_W-1:0] pixel_addr3;
   logic [ADDR_W-1:0] pixel_addr4;
   logic [ADDR_W-1:0] pixel_addr5;
   logic [ADDR_W-1:0] pixel_addr6;
   logic [ADDR_W-1:0] pixel_addr7;
   logic [ADDR_W-1:0] pixel_addr8;
   logic              load;
   logic              load_full_patch;
   logic              patch_valid;
   logic [4:0]        out_row;
   logic [4:0]        out_col;
   logic              busy;
   logic              done;
   logic [2:0]        state_dbg;

   modport master (
      output start, patch_ready,
      input  pixel_addr0, pixel_addr1, pixel_addr2,
      input  pixel_addr3, pixel_addr4, pixel_addr5,
      input  pixel_addr6, pixel_addr7, pixel_addr8,
      input  load, load_full_patch, patch_valid,
      input  out_row, out_col, busy, done, state_dbg
   );

   modport slave (
      input  start, patch_ready,
      output pixel_addr0, pixel_addr1, pixel_addr2,
      output pixel_addr3, pixel_addr4, pixel_addr5,
      output pixel_addr6, pixel_addr7, pixel_addr8,
      output load, load_full_patch, patch_valid,
      output out_row, out_col, busy, done, state_dbg
   );

endinterface

// File: rtl/patch_scan_ctrl.sv
// 3x3 patch scan sequencer: walks the window column by column, top to bottom,
// drives the nine memory read addresses and the patch latch strobes, and hands
// each latched patch downstream over a valid/ready handshake.
module patch_scan_ctrl #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10
) (
   input logic               clk,
   input logic               rst,
   patch_scan_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_LOAD  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [4:0]        ROW_LAST = 5'(IMG_H - 3);
   localparam logic [4:0]        COL_LAST = 5'(IMG_W - 3);
   localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);

   state_t            state;
   logic [4:0]        row;
   logic [4:0]        col;
   logic              load_q;
   logic              full_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] addr [9];

   // Window addresses from the counters; valid in every state, sampled in ISSUE.
   always_comb begin
      base_addr = ADDR_W'(row) * W_A + ADDR_W'(col);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            addr[3*r+c] = base_addr + ADDR_W'(r * IMG_W + c);
         end
      end
   end

   // Scan FSM with counters and all strobes registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         row     <= '0;
         col     <= '0;
         load_q  <= 1'b0;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  row    <= '0;
                  col    <= '0;
                  busy_q <= 1'b1;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Memories capture data this cycle; latch it on the next one.
               // The first patch of a column has no rows above to shift up.
               load_q <= 1'b1;
               full_q <= (row == '0);
               state  <= S_LOAD;
            end
            S_LOAD: begin
               load_q  <= 1'b0;
               full_q  <= 1'b0;
               valid_q <= 1'b1;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.patch_ready) begin
                  valid_q <= 1'b0;
                  if (row == ROW_LAST && col == COL_LAST) begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     if (row == ROW_LAST) begin
                        row <= '0;
                        col <= col + 5'd1;
                     end else begin
                        row <= row + 5'd1;
                     end
                     state <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               load_q  <= 1'b0;
               full_q  <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.pixel_addr0     = addr[0];
   assign bus.pixel_addr1     = addr[1];
   assign bus.pixel_addr2     = addr[2];
   assign bus.pixel_addr3     = addr[3];
   assign bus.pixel_addr4     = addr[4];
   assign bus.pixel_addr5     = addr[5];
   assign bus.pixel_addr6     = addr[6];
   assign bus.pixel_addr7     = addr[7];
   assign bus.pixel_addr8     = addr[8];
   assign bus.load            = load_q;
   assign bus.load_full_patch = full_q;
   assign bus.patch_valid     = valid_q;
   assign bus.out_row         = row;
   assign bus.out_col         = col;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.state_dbg       = state;

endmodule
